// File: rtl/lisnoc_dma_wbslave_irq_pkg.sv
// Shared request-table layout and register map for the LISNoC DMA Wishbone slave.
package lisnoc_dma_wbslave_irq_pkg;

  localparam int DMA_REQUEST_WIDTH = 103;
  localparam int DMA_REQMASK_WIDTH = 5;

  localparam int DMA_REQFIELD_LADDR_WIDTH = 32;
  localparam int DMA_REQFIELD_SIZE_WIDTH  = 32;
  localparam int DMA_REQFIELD_RTILE_WIDTH = 6;
  localparam int DMA_REQFIELD_RADDR_WIDTH = 32;

  localparam int DMA_REQFIELD_LADDR_MSB = 102;
  localparam int DMA_REQFIELD_LADDR_LSB = 71;
  localparam int DMA_REQFIELD_SIZE_MSB  = 70;
  localparam int DMA_REQFIELD_SIZE_LSB  = 39;
  localparam int DMA_REQFIELD_RTILE_MSB = 38;
  localparam int DMA_REQFIELD_RTILE_LSB = 33;
  localparam int DMA_REQFIELD_RADDR_MSB = 32;
  localparam int DMA_REQFIELD_RADDR_LSB = 1;
  localparam int DMA_REQFIELD_DIR       = 0;

  localparam logic [2:0] DMA_CTRL_TILEID  = 3'd0;
  localparam logic [2:0] DMA_CTRL_ENTRIES = 3'd1;
  localparam logic [2:0] DMA_CTRL_IRQPEND = 3'd2;
  localparam logic [2:0] DMA_CTRL_IRQMASK = 3'd3;
  localparam logic [2:0] DMA_STATUS_WORD  = 3'd5;

  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_ACK,
    RESP_ERR
  } wb_resp_e;

  // The bus word lands in every field at once; the one-hot select tells the table which to keep.
  function automatic logic [DMA_REQUEST_WIDTH-1:0] dma_req_from_word(input logic [31:0] d);
    logic [DMA_REQUEST_WIDTH-1:0] r;
    r = '0;
    r[DMA_REQFIELD_LADDR_MSB:DMA_REQFIELD_LADDR_LSB] = d;
    r[DMA_REQFIELD_SIZE_MSB:DMA_REQFIELD_SIZE_LSB]   = d;
    r[DMA_REQFIELD_RTILE_MSB:DMA_REQFIELD_RTILE_LSB] = d[DMA_REQFIELD_RTILE_WIDTH-1:0];
    r[DMA_REQFIELD_RADDR_MSB:DMA_REQFIELD_RADDR_LSB] = d;
    r[DMA_REQFIELD_DIR] = d[0];
    return r;
  endfunction

endpackage

// File: rtl/lisnoc_dma_wbslave_irq_irqctrl.sv
// Per-entry completion interrupt: done edge detect, pending (W1C) and mask registers.
module lisnoc_dma_irqctrl #(
  parameter int table_entries = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [table_entries-1:0] i_done,
  input  logic                     i_clr_en,
  input  logic [table_entries-1:0] i_clr_bits,
  input  logic                     i_mask_we,
  input  logic [table_entries-1:0] i_mask_bits,
  output logic [table_entries-1:0] o_pending,
  output logic [table_entries-1:0] o_mask,
  output logic                     o_irq
);

  logic [table_entries-1:0] r_done_q;
  logic [table_entries-1:0] r_pending;
  logic [table_entries-1:0] r_mask;
  logic                     r_irq;
  logic [table_entries-1:0] w_rise;
  logic [table_entries-1:0] w_clr;

  assign w_rise = i_done & ~r_done_q;
  assign w_clr  = i_clr_en ? i_clr_bits : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_done_q  <= '0;
      r_pending <= '0;
      r_mask    <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_done_q  <= i_done;
      // OR-ing the rise in last lets a simultaneous set beat the clear.
      r_pending <= (r_pending & ~w_clr) | w_rise;
      if (i_mask_we) r_mask <= i_mask_bits;
      r_irq     <= |(r_pending & r_mask);
    end
  end

  assign o_pending = r_pending;
  assign o_mask    = r_mask;
  assign o_irq     = r_irq;

endmodule

// File: rtl/lisnoc_dma_wbslave_irq.sv
// Wishbone slave that programs the DMA request table and exposes the completion interrupt.
module lisnoc_dma_wbslave_irq
  import lisnoc_dma_wbslave_irq_pkg::*;
#(
  parameter int          table_entries = 4,
  parameter logic [31:0] tileid        = 32'd0,
  localparam int         ptrw          = (table_entries > 1) ? $clog2(table_entries) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [31:0]                  wb_if_adr_i,
  input  logic [31:0]                  wb_if_dat_i,
  input  logic                         wb_if_cyc_i,
  input  logic                         wb_if_stb_i,
  input  logic                         wb_if_we_i,
  output logic [31:0]                  wb_if_dat_o,
  output logic                         wb_if_ack_o,
  output logic                         wb_if_err_o,
  output logic [DMA_REQUEST_WIDTH-1:0] if_write_req,
  output logic [ptrw-1:0]              if_write_pos,
  output logic [DMA_REQMASK_WIDTH-1:0] if_write_select,
  output logic                         if_write_en,
  output logic [ptrw-1:0]              if_valid_pos,
  output logic                         if_valid_set,
  output logic                         if_valid_en,
  output logic                         if_validrd_en,
  input  logic [table_entries-1:0]     done,
  output logic                         irq
);

  typedef logic [table_entries-1:0] ent_vec_t;

  logic                    w_req;
  logic                    w_tbl;
  logic [ptrw-1:0]         w_entry;
  logic [2:0]              w_word;
  logic                    w_entry_bad;
  logic [(1<<ptrw)-1:0]    w_done_pad;
  logic                    w_done_sel;
  wb_resp_e                w_resp;
  logic                    w_fwr, w_vwr, w_vrd, w_clr, w_mask_we;
  logic [31:0]             w_rdata;
  ent_vec_t                w_wbits, w_pending, w_mask;
  logic                    w_unused;

  assign w_req       = wb_if_cyc_i & wb_if_stb_i & ~wb_if_ack_o & ~wb_if_err_o;
  assign w_tbl       = wb_if_adr_i[12];
  assign w_entry     = wb_if_adr_i[ptrw+4:5];
  assign w_word      = wb_if_adr_i[4:2];
  assign w_entry_bad = (32'(w_entry) >= 32'(table_entries));
  assign w_wbits     = ent_vec_t'(wb_if_dat_i);
  assign w_unused    = ^wb_if_adr_i;

  // Padded so an out-of-range entry index never selects beyond the done vector.
  always_comb begin
    w_done_pad = '0;
    w_done_pad[table_entries-1:0] = done;
  end
  assign w_done_sel = w_done_pad[w_entry];

  always_comb begin
    w_resp    = RESP_NONE;
    w_fwr     = 1'b0;
    w_vwr     = 1'b0;
    w_vrd     = 1'b0;
    w_clr     = 1'b0;
    w_mask_we = 1'b0;
    w_rdata   = '0;
    if (w_req) begin
      if (w_tbl) begin
        if (!w_entry_bad && (w_word < 3'(DMA_REQMASK_WIDTH))) begin
          w_resp = RESP_ACK;
          w_fwr  = wb_if_we_i;
        end else if (!w_entry_bad && (w_word == DMA_STATUS_WORD)) begin
          w_resp  = RESP_ACK;
          w_vwr   = wb_if_we_i;
          w_vrd   = ~wb_if_we_i;
          w_rdata = {31'b0, w_done_sel};
        end else begin
          w_resp = RESP_ERR;
        end
      end else begin
        case (w_word)
          DMA_CTRL_TILEID: begin
            w_resp  = RESP_ACK;
            w_rdata = tileid;
          end
          DMA_CTRL_ENTRIES: begin
            w_resp  = RESP_ACK;
            w_rdata = 32'(table_entries);
          end
          DMA_CTRL_IRQPEND: begin
            w_resp  = RESP_ACK;
            w_clr   = wb_if_we_i;
            w_rdata = 32'(w_pending);
          end
          DMA_CTRL_IRQMASK: begin
            w_resp    = RESP_ACK;
            w_mask_we = wb_if_we_i;
            w_rdata   = 32'(w_mask);
          end
          default: w_resp = RESP_ERR;
        endcase
      end
      if (wb_if_we_i || (w_resp != RESP_ACK)) w_rdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_if_ack_o     <= 1'b0;
      wb_if_err_o     <= 1'b0;
      wb_if_dat_o     <= '0;
      if_write_en     <= 1'b0;
      if_write_pos    <= '0;
      if_write_select <= '0;
      if_write_req    <= '0;
      if_valid_en     <= 1'b0;
      if_validrd_en   <= 1'b0;
      if_valid_pos    <= '0;
      if_valid_set    <= 1'b0;
    end else begin
      wb_if_ack_o     <= (w_resp == RESP_ACK);
      wb_if_err_o     <= (w_resp == RESP_ERR);
      wb_if_dat_o     <= w_rdata;
      if_write_en     <= w_fwr;
      if_write_pos    <= w_fwr ? w_entry : '0;
      if_write_select <= w_fwr ? (DMA_REQMASK_WIDTH'(1) << w_word) : '0;
      if_write_req    <= w_fwr ? dma_req_from_word(wb_if_dat_i) : '0;
      if_valid_en     <= w_vwr;
      if_validrd_en   <= w_vrd;
      if_valid_pos    <= (w_vwr | w_vrd) ? w_entry : '0;
      if_valid_set    <= w_vwr | (w_vrd & ~w_done_sel);
    end
  end

  lisnoc_dma_irqctrl #(
    .table_entries(table_entries)
  ) u_irqctrl (
    .clk        (clk),
    .rst        (rst),
    .i_done     (done),
    .i_clr_en   (w_clr),
    .i_clr_bits (w_wbits),
    .i_mask_we  (w_mask_we),
    .i_mask_bits(w_wbits),
    .o_pending  (w_pending),
    .o_mask     (w_mask),
    .o_irq      (irq)
  );

endmodule

// File: tb/tb_lisnoc_dma_wbslave_irq.sv
// Scoreboard bench: directed Wishbone transfers against a 4-entry and a 3-entry slave.
module tb_lisnoc_dma_wbslave_irq;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [31:0] adr4, dat4, dato4, adr3, dat3, dato3;
  logic cyc4, stb4, we4, ack4, err4, cyc3, stb3, we3, ack3, err3;
  logic [102:0] wreq4, wreq3;
  logic [1:0] wpos4, vpos4, wpos3, vpos3;
  logic [4:0] wsel4, wsel3;
  logic wen4, vset4, ven4, vrd4, irq4, wen3, vset3, ven3, vrd3, irq3;
  logic [3:0] done4;
  logic [2:0] done3;

  lisnoc_dma_wbslave_irq #(.table_entries(4), .tileid(32'h7)) dut4 (
    .clk(clk), .rst(rst), .wb_if_adr_i(adr4), .wb_if_dat_i(dat4), .wb_if_cyc_i(cyc4),
    .wb_if_stb_i(stb4), .wb_if_we_i(we4), .wb_if_dat_o(dato4), .wb_if_ack_o(ack4),
    .wb_if_err_o(err4), .if_write_req(wreq4), .if_write_pos(wpos4), .if_write_select(wsel4),
    .if_write_en(wen4), .if_valid_pos(vpos4), .if_valid_set(vset4), .if_valid_en(ven4),
    .if_validrd_en(vrd4), .done(done4), .irq(irq4));

  lisnoc_dma_wbslave_irq #(.table_entries(3), .tileid(32'h9)) dut3 (
    .clk(clk), .rst(rst), .wb_if_adr_i(adr3), .wb_if_dat_i(dat3), .wb_if_cyc_i(cyc3),
    .wb_if_stb_i(stb3), .wb_if_we_i(we3), .wb_if_dat_o(dato3), .wb_if_ack_o(ack3),
    .wb_if_err_o(err3), .if_write_req(wreq3), .if_write_pos(wpos3), .if_write_select(wsel3),
    .if_write_en(wen3), .if_valid_pos(vpos3), .if_valid_set(vset3), .if_valid_en(ven3),
    .if_validrd_en(vrd3), .done(done3), .irq(irq3));

  typedef struct packed {
    logic        ack;
    logic        err;
    logic        wen;
    logic [1:0]  wpos;
    logic [4:0]  wsel;
    logic [31:0] wsize;
    logic        ven;
    logic        vrd;
    logic        vset;
    logic [1:0]  vpos;
    logic [31:0] dat;
  } resp_t;

  resp_t q4[$];
  resp_t q3[$];
  int total = 0;
  int bad = 0;

  function automatic resp_t r_ack(input logic [31:0] d);
    resp_t r = '0;
    r.ack = 1'b1; r.dat = d;
    return r;
  endfunction
  function automatic resp_t r_err();
    resp_t r = '0;
    r.err = 1'b1;
    return r;
  endfunction
  function automatic resp_t r_fw(input logic [1:0] p, input logic [4:0] s, input logic [31:0] sz);
    resp_t r = '0;
    r.ack = 1'b1; r.wen = 1'b1; r.wpos = p; r.wsel = s; r.wsize = sz;
    return r;
  endfunction
  function automatic resp_t r_vrd(input logic [1:0] p, input logic s, input logic [31:0] d);
    resp_t r = '0;
    r.ack = 1'b1; r.vrd = 1'b1; r.vpos = p; r.vset = s; r.dat = d;
    return r;
  endfunction
  function automatic resp_t r_vw(input logic [1:0] p);
    resp_t r = '0;
    r.ack = 1'b1; r.ven = 1'b1; r.vpos = p; r.vset = 1'b1;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic mon_step(input string nm, input resp_t o, inout resp_t q[$]);
    resp_t e;
    if (o.ack === 1'b1 || o.err === 1'b1) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL %s_unexpected: got %h want none", nm, o);
      end else begin
        e = q.pop_front();
        if (o !== e) begin
          bad++;
          $display("FAIL %s_resp: got %h want %h", nm, o, e);
        end
      end
    end else if (o != '0) begin
      total++; bad++;
      $display("FAIL %s_idle: got %h want 0", nm, o);
    end
  endtask

  always @(negedge clk) begin
    mon_step("dut4", {ack4, err4, wen4, wpos4, wsel4, wreq4[70:39], ven4, vrd4, vset4, vpos4, dato4}, q4);
    mon_step("dut3", {ack3, err3, wen3, wpos3, wsel3, wreq3[70:39], ven3, vrd3, vset3, vpos3, dato3}, q3);
  end

  task automatic drive(input bit d3, input logic [31:0] a, input logic [31:0] d, input logic w, input logic act);
    if (d3) begin adr3 = a; dat3 = d; we3 = w; cyc3 = act; stb3 = act; end
    else    begin adr4 = a; dat4 = d; we4 = w; cyc4 = act; stb4 = act; end
  endtask

  task automatic wb(input bit d3, input logic [31:0] a, input logic [31:0] d, input logic w, input resp_t e);
    if (d3) q3.push_back(e); else q4.push_back(e);
    drive(d3, a, d, w, 1'b1);
    @(posedge clk); #1;
    drive(d3, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acks, consec;
    logic prev;
    rst = 1'b1; done4 = '0; done3 = '0;
    drive(0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out4", 32'(|{dato4, ack4, err4, wreq4, wpos4, wsel4, wen4, vpos4, vset4, ven4, vrd4, irq4}), 0);
    @(posedge clk); #1 rst = 1'b0;

    wb(0, 32'h000, 0, 0, r_ack(32'h7));
    wb(0, 32'h004, 0, 0, r_ack(32'h4));
    wb(0, 32'h1044, 32'h1000, 1, r_fw(2'd2, 5'b00010, 32'h1000));
    done4 = 4'b1000;
    wb(0, 32'h1074, 0, 0, r_vrd(2'd3, 1'b0, 32'h1));
    wb(0, 32'h1054, 0, 0, r_vrd(2'd2, 1'b1, 32'h0));
    wb(0, 32'h1034, 32'hFFFF_FFFF, 1, r_vw(2'd1));
    wb(0, 32'h1020, 0, 0, r_ack(32'h0));
    wb(0, 32'h1018, 0, 0, r_err());
    wb(0, 32'h101C, 32'h1, 1, r_err());
    wb(0, 32'h010, 0, 0, r_err());
    wb(0, 32'h000, 32'hFFFF, 1, r_ack(32'h0));
    wb(0, 32'h000, 0, 0, r_ack(32'h7));

    wb(1, 32'h1018, 0, 0, r_err());
    wb(1, 32'h1064, 32'h1004, 1, r_err());
    wb(1, 32'h1074, 0, 0, r_err());
    wb(1, 32'h1054, 0, 0, r_vrd(2'd2, 1'b1, 32'h0));
    wb(1, 32'h004, 0, 0, r_ack(32'h3));

    wb(0, 32'h008, 32'hF, 1, r_ack(32'h0));
    wb(0, 32'h008, 0, 0, r_ack(32'h0));
    wb(0, 32'h00C, 32'h5, 1, r_ack(32'h0));
    wb(0, 32'h00C, 0, 0, r_ack(32'h5));
    chk("irq_idle", 32'(irq4), 0);
    done4 = 4'b1100;
    @(posedge clk); #1 done4 = 4'b1000;
    @(negedge clk); chk("irq_edge_plus1", 32'(irq4), 0);
    @(negedge clk); chk("irq_edge_plus2", 32'(irq4), 1);
    @(posedge clk); #1;
    wb(0, 32'h008, 0, 0, r_ack(32'h4));

    q4.push_back(r_ack(32'h0));
    drive(0, 32'h008, 32'h4, 1, 1);
    @(posedge clk); #1 drive(0, 0, 0, 0, 0);
    @(negedge clk); chk("irq_ack_cycle", 32'(irq4), 1);
    @(negedge clk); chk("irq_after_clear", 32'(irq4), 0);
    @(posedge clk); #1;

    done4 = 4'b1010;
    @(posedge clk); #1 done4 = 4'b1000;
    repeat (3) @(posedge clk);
    #1 chk("irq_masked", 32'(irq4), 0);
    wb(0, 32'h008, 0, 0, r_ack(32'h2));

    q4.push_back(r_ack(32'h0));
    drive(0, 32'h008, 32'h2, 1, 1);
    done4 = 4'b1010;
    @(posedge clk); #1 drive(0, 0, 0, 0, 0); done4 = 4'b1000;
    @(posedge clk); #1;
    wb(0, 32'h008, 0, 0, r_ack(32'h2));
    wb(0, 32'h008, 32'h2, 1, r_ack(32'h0));
    wb(0, 32'h008, 0, 0, r_ack(32'h0));

    for (int k = 0; k < 3; k++) q4.push_back(r_fw(2'd0, 5'b00001, 32'h1000));
    drive(0, 32'h1000, 32'h1000, 1, 1);
    acks = 0; consec = 0; prev = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 5) drive(0, 0, 0, 0, 0);
      @(negedge clk);
      if (ack4) begin
        acks++;
        if (prev) consec++;
      end
      prev = ack4;
    end
    chk("held_acks", 32'(acks), 3);
    chk("held_consec", 32'(consec), 0);
    @(posedge clk); #1;

    drive(0, 32'h00C, 32'h3, 1, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_no_ack", 32'(ack4), 0);
    chk("rst_outputs", 32'(|{dato4, ack4, err4, wreq4, wpos4, wsel4, wen4, vpos4, vset4, ven4, vrd4, irq4}), 0);
    @(posedge clk); #1 rst = 1'b0;
    q4.push_back(r_ack(32'h0));
    @(posedge clk); #1 drive(0, 0, 0, 0, 0);
    @(posedge clk); #1;
    wb(0, 32'h00C, 0, 0, r_ack(32'h3));
    wb(0, 32'h008, 0, 0, r_ack(32'h8));
    chk("irq_after_rst", 32'(irq4), 0);

    repeat (2) @(posedge clk);
    chk("q4_drained", 32'(q4.size()), 0);
    chk("q3_drained", 32'(q3.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
